// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, register-zero constant and packed-port helpers
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 16;
    localparam int NUM_RD_DEF   = 5;
    localparam int ZERO_REG     = 0;

    // LSB position of port idx inside a packed bus of w-bit fields
    function automatic int port_lsb(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int port_msb(input int idx, input int w);
        return idx * w + w - 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with flush/clear/set priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pend_next
);

    logic [NUM_REGS-1:0] pend;

    // Apply in increasing priority: flush, writeback clear, issue set
    always_comb begin
        pend_next = flush ? '0 : pend;
        if (wr_en) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (iss_en) begin
            pend_next[iss_addr] = 1'b1;
        end
        pend_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register bank with write bypass and RAW scoreboard
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = NUM_RD_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic                     any_busy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [NUM_REGS-1:0]      pend_next;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
    logic [NUM_RD-1:0]        rd_busy_nxt;
    logic                     wr_ok;

    assign wr_ok = wr_en && (wr_addr != ZERO_ADDR);

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .flush     (flush),
        .pend_next (pend_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read mux with same-cycle write bypass; busy follows next-state pending bits
    always_comb begin
        logic [ADDR_W-1:0] a;
        a           = '0;
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
            if (a != ZERO_ADDR) begin
                if (wr_ok && (wr_addr == a)) begin
                    rd_data_nxt[port_lsb(i, DATA_W) +: DATA_W] = wr_data;
                end else begin
                    rd_data_nxt[port_lsb(i, DATA_W) +: DATA_W] = regs[a];
                end
            end
            rd_busy_nxt[i] = pend_next[a];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_busy  <= '0;
            any_busy <= 1'b0;
        end else begin
            rd_data  <= rd_data_nxt;
            rd_busy  <= rd_busy_nxt;
            any_busy <= |pend_next;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - randomized and directed bench for regfile_mp_sb against a behavioural model
module tb_regfile_mp_sb;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int NP = 5;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             flush;
    logic             any_busy;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .any_busy (any_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register values, pending set, expected outputs
    logic [DW-1:0]    mreg [NR];
    bit               mpend [NR];
    logic [NP*DW-1:0] e_data;
    logic [NP-1:0]    e_busy;
    logic             e_any;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                mreg[r]  = '0;
                mpend[r] = 1'b0;
            end
            e_data = '0;
            e_busy = '0;
            e_any  = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                if (a == 0)
                    e_data[p*DW +: DW] = '0;
                else if (wr_en && int'(wr_addr) == a)
                    e_data[p*DW +: DW] = wr_data;
                else
                    e_data[p*DW +: DW] = mreg[a];
            end
            if (flush)
                for (int r = 0; r < NR; r++) mpend[r] = 1'b0;
            if (wr_en) mpend[wr_addr] = 1'b0;
            if (iss_en) mpend[iss_addr] = 1'b1;
            mpend[0] = 1'b0;
            e_any = 1'b0;
            for (int r = 0; r < NR; r++) e_any = e_any | mpend[r];
            for (int p = 0; p < NP; p++) e_busy[p] = mpend[rd_addr[p*AW +: AW]];
            if (wr_en && wr_addr != 0) mreg[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_rd_data", 128'(rd_data), 128'(e_data));
            chk("model_rd_busy", 128'(rd_busy), 128'(e_busy));
            chk("model_any_busy", 128'(any_busy), 128'(e_any));
        end
    end

    task automatic ctl(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia, input logic fl);
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; flush = fl;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        ctl(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        set_rd(0, 0); set_rd(1, 1); set_rd(2, 5); set_rd(3, 9); set_rd(4, 15);
        @(negedge clk);
        chk("reset_rd_data", 128'(rd_data), 128'(0));
        chk("reset_rd_busy", 128'(rd_busy), 128'(0));
        chk("reset_any_busy", 128'(any_busy), 128'(0));

        ctl(1, 3, 16'hBEEF, 0, 0, 0);
        @(negedge clk);
        ctl(0, 0, 0, 0, 0, 0); set_rd(0, 3);
        @(negedge clk);
        chk("read_r3", 128'(rd_data[0 +: DW]), 128'(16'hBEEF));
        ctl(1, 0, 16'h1234, 0, 0, 0);
        @(negedge clk);
        ctl(0, 0, 0, 0, 0, 0); set_rd(0, 0);
        @(negedge clk);
        chk("read_r0", 128'(rd_data[0 +: DW]), 128'(0));

        ctl(1, 7, 16'h0001, 0, 0, 0);
        @(negedge clk);
        ctl(1, 7, 16'hA5A5, 0, 0, 0); set_rd(0, 7); set_rd(4, 7);
        @(negedge clk);
        chk("bypass_p0", 128'(rd_data[0 +: DW]), 128'(16'hA5A5));
        chk("bypass_p4", 128'(rd_data[4*DW +: DW]), 128'(16'hA5A5));

        ctl(0, 0, 0, 1, 5, 0); set_rd(0, 5);
        @(negedge clk);
        chk("issue_busy", 128'(rd_busy[0]), 128'(1));
        chk("issue_any", 128'(any_busy), 128'(1));
        ctl(1, 5, 16'h0042, 0, 0, 0);
        @(negedge clk);
        chk("wb_busy", 128'(rd_busy[0]), 128'(0));
        chk("wb_data", 128'(rd_data[0 +: DW]), 128'(16'h0042));
        ctl(1, 5, 16'h0099, 1, 5, 0);
        @(negedge clk);
        chk("set_wins", 128'(rd_busy[0]), 128'(1));

        ctl(0, 0, 0, 1, 2, 0);
        @(negedge clk);
        ctl(0, 0, 0, 1, 9, 0);
        @(negedge clk);
        ctl(0, 0, 0, 1, 4, 1); set_rd(0, 2); set_rd(1, 9); set_rd(2, 4); set_rd(3, 5);
        @(negedge clk);
        chk("flush_busy", 128'(rd_busy[3:0]), 128'(4'b0100));
        chk("flush_any", 128'(any_busy), 128'(1));
        ctl(0, 0, 0, 1, 0, 1); set_rd(0, 0);
        @(negedge clk);
        chk("iss_r0_busy", 128'(rd_busy[0]), 128'(0));
        chk("iss_r0_any", 128'(any_busy), 128'(0));

        ctl(1, 6, 16'h7777, 1, 6, 0);
        @(negedge clk);
        ctl(0, 0, 0, 0, 0, 0); set_rd(0, 6);
        @(negedge clk);
        chk("r6_data", 128'(rd_data[0 +: DW]), 128'(16'h7777));
        chk("r6_busy", 128'(rd_busy[0]), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", 128'(rd_data), 128'(0));
        chk("async_rst_busy", 128'(rd_busy), 128'(0));
        chk("async_rst_any", 128'(any_busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_data", 128'(rd_data[0 +: DW]), 128'(0));
        chk("post_rst_busy", 128'(rd_busy[0]), 128'(0));

        for (int c = 0; c < 600; c++) begin
            int amax;
            amax = ($urandom_range(0, 1) == 0) ? 3 : 15;
            for (int p = 0; p < NP; p++) set_rd(p, $urandom_range(0, amax));
            ctl(1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)), DW'($urandom),
                1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, amax)),
                1'($urandom_range(0, 15) == 0));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register bank: the next generation of the processor's fixed 16x16, 5-read register bank.
- Provides configurable depth, width and read-port count, and a synchronous write with same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so the issue stage can detect RAW hazards.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, number of architectural registers (power of two, >=2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).
- NUM_RD, 5, number of read ports.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data, port i at [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered pending flag of the addressed register, per port.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write register.
- wr_data  in  DATA_W  write data.
- iss_en  in  1  marks iss_addr as pending (instruction issued with that destination).
- iss_addr  in  ADDR_W  destination being issued.
- flush  in  1  synchronous clear of all pending bits.
- any_busy  out  1  registered OR of all pending bits.

Behaviour:
- Reset (async, rst=1): all registers 0, all pending bits 0, rd_data=0, rd_busy=0, any_busy=0. Reset mid-operation discards in-flight writes/issues; first edge after deassertion behaves normally.
- Register 0 hardwired: reads always return 0 and busy 0; writes and issues to address 0 are ignored.
- Write: on rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read latency 1 cycle: rd_data[i] at edge k+1 reflects rd_addr[i] sampled at edge k.
- Bypass: if wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i] in the same cycle, rd_data[i] <= wr_data (new value, not stale). This applies independently to every port; several ports may hit the same address.
- Scoreboard, per register r!=0, evaluated at each edge:
  - Set when iss_en && iss_addr==r.
  - Clear when wr_en && wr_addr==r.
  - Simultaneous set and clear of the same r: set wins (a re-issue overrides the older writeback).
  - Set and clear to different registers in the same cycle both take effect.
  - flush=1: all bits cleared, except that a same-cycle iss_en still sets its bit (flush then issue).
- rd_busy[i] <= next-state pending bit of rd_addr[i], i.e. it includes same-cycle clear (bypassed write gives busy 0) and same-cycle set (busy 1).
- any_busy <= OR of next-state pending bits.
- Write to a non-pending register is legal: data is written and the scoreboard is unchanged.
- Issue to an already pending register: the bit stays 1 (no counting; single outstanding write per register).
- No X propagation: every address value is decoded; there are no default-X branches.

Decomposition:
- Package regfile_pkg holds the DATA_W/NUM_REGS/NUM_RD defaults, the ZERO_REG constant (0), and helper functions for packed-port slicing.
- Sub-module regfile_scoreboard (NUM_REGS pending bits, set/clear/flush priority, next-state vector output) is natural. The top level instantiates it and implements storage, read muxes and bypass.

Test Plan:
- Reset then read ports 0..4 at addrs 0,1,5,9,15 -> all rd_data=0x0000, rd_busy=0, any_busy=0.
- Write R3=0xBEEF at cycle k, read R3 at k+1 -> rd_data=0xBEEF at edge k+2. Write R0=0x1234 then read R0 -> 0x0000.
- Same-cycle bypass: wr R7=0xA5A5 with ports 0 and 4 reading R7, old R7=0x0001 -> both ports show 0xA5A5 next edge.
- Scoreboard: issue R5 -> next edge reading R5 gives rd_busy=1, any_busy=1. Writeback R5=0x0042 while reading R5 -> rd_busy=0, rd_data=0x0042. Issue and write R5 in the same cycle -> busy stays 1.
- Flush with R2, R9 pending plus same-cycle issue R4 -> only R4 pending afterwards, any_busy=1. Issue R0 -> never busy.
- Assert rst asynchronously mid-cycle with R6=0x7777 pending -> outputs go 0 immediately without a clock edge. After release, reading R6 gives 0x0000 and busy 0.
